// File: rtl/flash_seq_pkg.sv
// Shared types and sizing helpers for the flash read sequencer.
package flash_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_PRECHG = 3'd2,
    ST_SENSE  = 3'd3,
    ST_LATCH  = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

  localparam int DEF_SETUP_CYC  = 2;
  localparam int DEF_PRECHG_CYC = 4;
  localparam int DEF_SENSE_CYC  = 8;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Phase counter must hold the longest phase length
  function automatic int phase_cnt_w(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return ($clog2(m + 1) > 1) ? $clog2(m + 1) : 1;
  endfunction

endpackage

// File: rtl/flash_onehot_dec.sv
// Binary-to-one-hot decoder with enable; all-zero output when disabled or index out of range.
module flash_onehot_dec #(
  parameter int IN_W  = 2,
  parameter int OUT_N = 4
) (
  input  logic              en,
  input  logic [IN_W-1:0]   idx,
  output logic [OUT_N-1:0]  onehot
);

  // Decode index to a single set bit
  always_comb begin
    onehot = '0;
    for (int i = 0; i < OUT_N; i++) begin
      if (en && (idx == IN_W'(i))) onehot[i] = 1'b1;
      else                         onehot[i] = 1'b0;
    end
  end

endmodule

// File: rtl/flash_read_sequencer.sv
// Read/verify sequencer driving NAND array select and sense strobes.
// Optional FLASH_SEQ_DOUBLE_SAMPLE_EN: two LATCH samples, AND-combined, mismatch flags an error.
module flash_read_sequencer
  import flash_seq_pkg::*;
#(
  parameter int NUM_BL     = 8,
  parameter int NUM_WL     = 4,
  parameter int NUM_BLK    = 2,
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int PRECHG_CYC = DEF_PRECHG_CYC,
  parameter int SENSE_CYC  = DEF_SENSE_CYC,
  localparam int BLK_W     = addr_w(NUM_BLK),
  localparam int WL_W      = addr_w(NUM_WL)
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [BLK_W-1:0]   req_blk,
  input  logic [WL_W-1:0]    req_wl,
  input  logic               req_verify,
  input  logic [NUM_BL-1:0]  req_expect,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [NUM_BL-1:0]  rsp_data,
  output logic               rsp_err,
  output logic [NUM_BLK-1:0] ssl_en,
  output logic [NUM_BLK-1:0] gsl_en,
  output logic [NUM_WL-1:0]  wl_sel,
  output logic               prechg,
  output logic               sen1,
  output logic               sen2,
  output logic               out_en,
  input  logic [NUM_BL-1:0]  sa_out
);

  localparam int CNT_W = phase_cnt_w(SETUP_CYC, PRECHG_CYC, SENSE_CYC);
  localparam logic [BLK_W:0] BLK_LIM = (BLK_W + 1)'(NUM_BLK);
  localparam logic [WL_W:0]  WL_LIM  = (WL_W + 1)'(NUM_WL);
`ifdef FLASH_SEQ_DOUBLE_SAMPLE_EN
  localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(1);
`else
  localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(0);
`endif

  state_e               state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 verify_r;
  logic                 bad_r;
  logic [NUM_BL-1:0]    expect_r;
  logic                 req_ready_r, rsp_valid_r, rsp_err_r;
  logic [NUM_BL-1:0]    rsp_data_r;
  logic [NUM_BLK-1:0]   ssl_en_r, gsl_en_r;
  logic [NUM_WL-1:0]    wl_sel_r;
  logic                 prechg_r, sen1_r, sen2_r, out_en_r;
  logic                 addr_ok_s;
  logic [NUM_BLK-1:0]   ssl_dec_s, gsl_dec_s;
  logic [NUM_WL-1:0]    wl_dec_s;
  logic [NUM_BL-1:0]    data_s;
  logic                 mism_s;
  logic                 err_s;
`ifdef FLASH_SEQ_DOUBLE_SAMPLE_EN
  logic [NUM_BL-1:0]    samp0_r;
`endif

  assign addr_ok_s = ({1'b0, req_blk} < BLK_LIM) && ({1'b0, req_wl} < WL_LIM);

  flash_onehot_dec #(.IN_W(BLK_W), .OUT_N(NUM_BLK)) u_ssl_dec (
    .en(addr_ok_s), .idx(req_blk), .onehot(ssl_dec_s));
  flash_onehot_dec #(.IN_W(BLK_W), .OUT_N(NUM_BLK)) u_gsl_dec (
    .en(addr_ok_s), .idx(req_blk), .onehot(gsl_dec_s));
  flash_onehot_dec #(.IN_W(WL_W), .OUT_N(NUM_WL)) u_wl_dec (
    .en(addr_ok_s), .idx(req_wl), .onehot(wl_dec_s));

  // Final sample and error evaluation at the last LATCH cycle
  always_comb begin
`ifdef FLASH_SEQ_DOUBLE_SAMPLE_EN
    data_s = samp0_r & sa_out;
    mism_s = (samp0_r != sa_out);
`else
    data_s = sa_out;
    mism_s = 1'b0;
`endif
    if (verify_r) err_s = mism_s || (data_s != expect_r);
    else          err_s = mism_s;
  end

  // Sequencer FSM with registered strobes and response
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      verify_r    <= 1'b0;
      bad_r       <= 1'b0;
      expect_r    <= '0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_data_r  <= '0;
      ssl_en_r    <= '0;
      gsl_en_r    <= '0;
      wl_sel_r    <= '0;
      prechg_r    <= 1'b0;
      sen1_r      <= 1'b0;
      sen2_r      <= 1'b0;
      out_en_r    <= 1'b0;
`ifdef FLASH_SEQ_DOUBLE_SAMPLE_EN
      samp0_r     <= '0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready_r <= 1'b0;
            verify_r    <= req_verify;
            expect_r    <= req_expect;
            bad_r       <= !addr_ok_s;
            if (addr_ok_s) begin
              state_r  <= ST_SETUP;
              cnt_r    <= CNT_W'(SETUP_CYC - 1);
              ssl_en_r <= ssl_dec_s;
              gsl_en_r <= gsl_dec_s;
              wl_sel_r <= wl_dec_s;
            end else begin
              // Out-of-range: one quiet cycle in LATCH with no strobes, then respond
              state_r <= ST_LATCH;
              cnt_r   <= '0;
            end
          end
        end
        ST_SETUP: begin
          if (cnt_r == '0) begin
            state_r  <= ST_PRECHG;
            cnt_r    <= CNT_W'(PRECHG_CYC - 1);
            prechg_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_PRECHG: begin
          if (cnt_r == '0) begin
            state_r  <= ST_SENSE;
            cnt_r    <= CNT_W'(SENSE_CYC - 1);
            prechg_r <= 1'b0;
            sen1_r   <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_SENSE: begin
          if (cnt_r == '0) begin
            state_r  <= ST_LATCH;
            cnt_r    <= LATCH_LOAD;
            sen1_r   <= 1'b0;
            sen2_r   <= 1'b1;
            out_en_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_LATCH: begin
          if (cnt_r == '0) begin
            state_r     <= ST_RESP;
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= bad_r ? '0 : data_s;
            rsp_err_r   <= bad_r ? 1'b1 : err_s;
            ssl_en_r    <= '0;
            gsl_en_r    <= '0;
            wl_sel_r    <= '0;
            sen2_r      <= 1'b0;
            out_en_r    <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
`ifdef FLASH_SEQ_DOUBLE_SAMPLE_EN
            samp0_r <= sa_out;
`endif
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_r     <= ST_IDLE;
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          req_ready_r <= 1'b1;
          rsp_valid_r <= 1'b0;
          ssl_en_r    <= '0;
          gsl_en_r    <= '0;
          wl_sel_r    <= '0;
          prechg_r    <= 1'b0;
          sen1_r      <= 1'b0;
          sen2_r      <= 1'b0;
          out_en_r    <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_err   = rsp_err_r;
  assign ssl_en    = ssl_en_r;
  assign gsl_en    = gsl_en_r;
  assign wl_sel    = wl_sel_r;
  assign prechg    = prechg_r;
  assign sen1      = sen1_r;
  assign sen2      = sen2_r;
  assign out_en    = out_en_r;

endmodule

// File: tb/tb_flash_read_sequencer.sv
// Directed self-checking bench for flash_read_sequencer (default and NUM_WL=3 instances).
module tb_flash_read_sequencer;

`ifdef FLASH_SEQ_DOUBLE_SAMPLE_EN
  localparam int LAT = 16;
`else
  localparam int LAT = 15;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_valid3, req_ready, req_ready3;
  logic       req_blk;
  logic [1:0] req_wl;
  logic       req_verify;
  logic [7:0] req_expect;
  logic       rsp_valid, rsp_valid3, rsp_ready, rsp_ready3;
  logic [7:0] rsp_data, rsp_data3;
  logic       rsp_err, rsp_err3;
  logic [1:0] ssl_en, gsl_en, ssl_en3, gsl_en3;
  logic [3:0] wl_sel;
  logic [2:0] wl_sel3;
  logic       prechg, sen1, sen2, out_en, prechg3, sen13, sen23, out_en3;
  logic [7:0] sa_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  flash_read_sequencer dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_blk(req_blk), .req_wl(req_wl), .req_verify(req_verify), .req_expect(req_expect),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ssl_en(ssl_en), .gsl_en(gsl_en), .wl_sel(wl_sel), .prechg(prechg), .sen1(sen1),
    .sen2(sen2), .out_en(out_en), .sa_out(sa_out));

  flash_read_sequencer #(.NUM_WL(3)) dut3 (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_blk(req_blk), .req_wl(req_wl), .req_verify(req_verify), .req_expect(req_expect),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3), .rsp_err(rsp_err3),
    .ssl_en(ssl_en3), .gsl_en(gsl_en3), .wl_sel(wl_sel3), .prechg(prechg3), .sen1(sen13),
    .sen2(sen23), .out_en(out_en3), .sa_out(sa_out));

  // Issue one request, model the sense amps (sa0 then sa1 while out_en), wait for the response
  task automatic run_req(input logic blk, input logic [1:0] wl, input logic verify,
                         input logic [7:0] expv, input logic [7:0] sa0, input logic [7:0] sa1,
                         output int lat, output logic [7:0] data, output logic err,
                         output logic [1:0] ssl_seen, output logic [1:0] gsl_seen,
                         output logic [3:0] wl_seen);
    int k;
    k = 0; lat = -1; data = 8'h00; err = 1'b0;
    ssl_seen = 2'b00; gsl_seen = 2'b00; wl_seen = 4'b0000;
    @(negedge clk);
    req_valid = 1'b1; req_blk = blk; req_wl = wl; req_verify = verify; req_expect = expv;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ssl_seen = ssl_seen | ssl_en;
      gsl_seen = gsl_seen | gsl_en;
      wl_seen  = wl_seen | wl_sel;
      if (out_en) begin
        sa_out = (k == 0) ? sa0 : sa1;
        k++;
      end
      if (rsp_valid) begin
        lat = i; data = rsp_data; err = rsp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
      failures++; $display("FAIL reset_rsp got valid=%0b err=%0b exp 0 0", rsp_valid, rsp_err);
    end
    checks++;
    if (rsp_data !== 8'h00) begin
      failures++; $display("FAIL reset_data got=%h exp=00", rsp_data);
    end
    checks++;
    if ({ssl_en, gsl_en, wl_sel, prechg, sen1, sen2, out_en} !== 12'h000) begin
      failures++; $display("FAIL reset_strobes got=%h exp=000", {ssl_en, gsl_en, wl_sel, prechg, sen1, sen2, out_en});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL reset_release got ready=%0b valid=%0b exp 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_read();
    int lat; logic [7:0] d; logic e; logic [1:0] s, g; logic [3:0] w;
    run_req(1'b1, 2'd2, 1'b0, 8'h00, 8'hA5, 8'hA5, lat, d, e, s, g, w);
    checks++;
    if (lat !== LAT) begin failures++; $display("FAIL read_latency got=%0d exp=%0d", lat, LAT); end
    checks++;
    if (d !== 8'hA5) begin failures++; $display("FAIL read_data got=%h exp=a5", d); end
    checks++;
    if (e !== 1'b0) begin failures++; $display("FAIL read_err got=%0b exp=0", e); end
    checks++;
    if (s !== 2'b10 || g !== 2'b10) begin failures++; $display("FAIL read_ssl_gsl got=%b/%b exp=10/10", s, g); end
    checks++;
    if (w !== 4'b0100) begin failures++; $display("FAIL read_wl got=%b exp=0100", w); end
  endtask

  task automatic test_verify();
    int lat; logic [7:0] d; logic e; logic [1:0] s, g; logic [3:0] w;
    run_req(1'b1, 2'd1, 1'b1, 8'h3C, 8'h3D, 8'h3D, lat, d, e, s, g, w);
    checks++;
    if (d !== 8'h3D || e !== 1'b1) begin failures++; $display("FAIL verify_mismatch got data=%h err=%0b exp 3d 1", d, e); end
    checks++;
    if (lat !== LAT) begin failures++; $display("FAIL verify_latency got=%0d exp=%0d", lat, LAT); end
    run_req(1'b0, 2'd0, 1'b1, 8'h3C, 8'h3C, 8'h3C, lat, d, e, s, g, w);
    checks++;
    if (d !== 8'h3C || e !== 1'b0) begin failures++; $display("FAIL verify_match got data=%h err=%0b exp 3c 0", d, e); end
    checks++;
    if (s !== 2'b01 || w !== 4'b0001) begin failures++; $display("FAIL verify_selects got=%b/%b exp=01/0001", s, w); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [7:0] d; logic e; logic any;
    lat = -1; d = 8'h00; e = 1'b0; any = 1'b0;
    rsp_ready3 = 1'b1; sa_out = 8'h77;
    @(negedge clk);
    req_valid3 = 1'b1; req_blk = 1'b0; req_wl = 2'd3; req_verify = 1'b0;
    @(posedge clk); #1;
    req_valid3 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      any = any | (|{ssl_en3, gsl_en3, wl_sel3, prechg3, sen13, sen23, out_en3});
      if (rsp_valid3 && lat < 0) begin lat = i; d = rsp_data3; e = rsp_err3; end
    end
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL oor_latency got=%0d exp=1", lat); end
    checks++;
    if (e !== 1'b1 || d !== 8'h00) begin failures++; $display("FAIL oor_rsp got data=%h err=%0b exp 00 1", d, e); end
    checks++;
    if (any !== 1'b0) begin failures++; $display("FAIL oor_strobes got=%0b exp=0", any); end
    checks++;
    if (rsp_valid3 !== 1'b0 || req_ready3 !== 1'b1) begin
      failures++; $display("FAIL oor_return got valid=%0b ready=%0b exp 0 1", rsp_valid3, req_ready3);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [7:0] d; logic e; logic [1:0] s, g; logic [3:0] w; logic unstable, rdy_hi;
    unstable = 1'b0; rdy_hi = 1'b0;
    rsp_ready = 1'b0;
    run_req(1'b0, 2'd1, 1'b0, 8'h00, 8'h5A, 8'h5A, lat, d, e, s, g, w);
    checks++;
    if (lat !== LAT || d !== 8'h5A) begin failures++; $display("FAIL bp_first got lat=%0d data=%h exp %0d 5a", lat, d, LAT); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h5A || rsp_err !== 1'b0) unstable = 1'b1;
      if (req_ready !== 1'b0) rdy_hi = 1'b1;
    end
    checks++;
    if (unstable !== 1'b0) begin failures++; $display("FAIL bp_stable got unstable=%0b exp=0", unstable); end
    checks++;
    if (rdy_hi !== 1'b0) begin failures++; $display("FAIL bp_req_ready got high=%0b exp=0", rdy_hi); end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL bp_handshake got valid=%0b ready=%0b exp 0 1", rsp_valid, req_ready);
    end
    sa_out = 8'hC3;
    req_valid = 1'b1; req_blk = 1'b1; req_wl = 2'd3; req_verify = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("FAIL b2b_accept got ready=%0b exp=0", req_ready); end
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = i; d = rsp_data; break; end
    end
    checks++;
    if (lat !== LAT || d !== 8'hC3) begin failures++; $display("FAIL b2b_rsp got lat=%0d data=%h exp %0d c3", lat, d, LAT); end
  endtask

  task automatic test_reset_mid();
    logic seen; logic spurious;
    seen = 1'b0; spurious = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_blk = 1'b1; req_wl = 2'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sen1) begin seen = 1'b1; break; end
    end
    checks++;
    if (seen !== 1'b1) begin failures++; $display("FAIL midrst_reach_sense got=%0b exp=1", seen); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ssl_en, gsl_en, wl_sel, prechg, sen1, sen2, out_en} !== 12'h000) begin
      failures++; $display("FAIL midrst_async got=%h exp=000", {ssl_en, gsl_en, wl_sel, prechg, sen1, sen2, out_en});
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid || sen1 || sen2) spurious = 1'b1;
    end
    checks++;
    if (spurious !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL midrst_idle got spurious=%0b ready=%0b exp 0 1", spurious, req_ready);
    end
  endtask

  task automatic test_sample_mode();
    int lat; logic [7:0] d; logic e; logic [1:0] s, g; logic [3:0] w;
    run_req(1'b0, 2'd3, 1'b0, 8'h00, 8'hFF, 8'hF0, lat, d, e, s, g, w);
`ifdef FLASH_SEQ_DOUBLE_SAMPLE_EN
    checks++;
    if (d !== 8'hF0 || e !== 1'b1 || lat !== 16) begin
      failures++; $display("FAIL double_sample got data=%h err=%0b lat=%0d exp f0 1 16", d, e, lat);
    end
`else
    checks++;
    if (d !== 8'hFF || e !== 1'b0 || lat !== 15) begin
      failures++; $display("FAIL single_sample got data=%h err=%0b lat=%0d exp ff 0 15", d, e, lat);
    end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 1'b0; req_valid3 = 1'b0; req_blk = 1'b0; req_wl = 2'd0;
    req_verify = 1'b0; req_expect = 8'h00; rsp_ready = 1'b1; rsp_ready3 = 1'b1;
    sa_out = 8'h00; rst_n = 1'b0;
    test_reset();
    test_read();
    test_verify();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    test_sample_mode();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
